// File: rtl/ip_result_store.sv
// ip_result_store: captures an operand and base address on start, waits a fixed
// compute latency, then writes NUM_OUT derived result fields to memory one per
// accepted request. Fields are stored at consecutive OUT_W/8-byte slots, and the
// final field is narrowed to LAST_BITS.
//
// Ports:
//   clock, reset       single clock, synchronous active-high reset
//   start_port         start request, sampled only while idle
//   input1, base_addr  operand and destination byte address, captured on start
//   done_port          one-cycle pulse, high in the cycle the last field is acked
//   busy               high while computing or writing
//   mem_req/mem_ack    write handshake; a transfer completes when both are high
//   mem_addr/mem_wdata/mem_size  write address, LSB-aligned data, size in bits
module ip_result_store #(
  parameter int unsigned IN_W      = 32,
  parameter int unsigned OUT_W     = 64,
  parameter int unsigned NUM_OUT   = 3,
  parameter int unsigned LAT       = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned LAST_BITS = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_port,
  input  logic [IN_W-1:0]   input1,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              done_port,
  output logic              busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [OUT_W-1:0]  mem_wdata,
  output logic [6:0]        mem_size,
  input  logic              mem_ack
);

  localparam int unsigned PW    = 2 * IN_W;
  // Wide enough to hold either the full product or a full field.
  localparam int unsigned XW    = (PW > OUT_W) ? PW : OUT_W;
  localparam int unsigned IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int unsigned CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int unsigned BYTES = OUT_W / 8;

  typedef enum logic [1:0] {StIdle, StCompute, StWrite} state_e;

  state_e              state_q, state_d;
  logic [IN_W-1:0]     in_q;
  logic [ADDR_W-1:0]   base_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [IDX_W-1:0]    idx_q;
  logic [OUT_W-1:0]    field_q [NUM_OUT];
  logic [OUT_W-1:0]    field_d [NUM_OUT];
  logic [PW-1:0]       prod;
  logic [XW-1:0]       fx;
  logic [OUT_W-1:0]    last_mask;
  logic                cnt_done;
  logic                last_idx;

  assign cnt_done  = (cnt_q == CNT_W'(LAT - 1));
  assign last_idx  = (idx_q == IDX_W'(NUM_OUT - 1));
  assign last_mask = OUT_W'({LAST_BITS{1'b1}});

  // Result fields derived from the captured operand; masking of the final
  // field happens here so the write path just forwards registered data.
  always_comb begin
    prod = PW'(in_q) * PW'(in_q);
    fx   = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (k == 0) begin
        fx = XW'(prod);
      end else if (k == 1) begin
        fx = XW'({in_q, in_q});
      end else begin
        fx = XW'(in_q + IN_W'(k));
      end
      field_d[k] = fx[OUT_W-1:0];
      if (k == NUM_OUT - 1) begin
        field_d[k] = field_d[k] & last_mask;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_size  = '0;
    done_port = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_port) state_d = StCompute;
      end
      StCompute: begin
        busy = 1'b1;
        if (cnt_done) state_d = StWrite;
      end
      StWrite: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = base_q + ADDR_W'(idx_q) * ADDR_W'(BYTES);
        for (int k = 0; k < NUM_OUT; k++) begin
          if (IDX_W'(k) == idx_q) mem_wdata = field_q[k];
        end
        mem_size = last_idx ? 7'(LAST_BITS) : 7'(OUT_W);
        if (mem_ack && last_idx) begin
          done_port = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      in_q    <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      for (int k = 0; k < NUM_OUT; k++) field_q[k] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && start_port) begin
        in_q   <= input1;
        base_q <= base_addr;
        cnt_q  <= '0;
      end
      if (state_q == StCompute) begin
        if (cnt_done) begin
          for (int k = 0; k < NUM_OUT; k++) field_q[k] <= field_d[k];
          idx_q <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
      if (state_q == StWrite && mem_ack && !last_idx) begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ip_result_store.sv
module tb_ip_result_store;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, start_port, mem_ack;
  logic [31:0] input1, base_addr;
  logic        done_port, busy, mem_req;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [6:0]  mem_size;

  logic        s_start, s_ack;
  logic [31:0] s_in, s_base;
  logic        s_done, s_busy, s_req;
  logic [31:0] s_addr;
  logic [63:0] s_wdata;
  logic [6:0]  s_size;

  ip_result_store u_dut (
    .clock(clock), .reset(reset), .start_port(start_port), .input1(input1),
    .base_addr(base_addr), .done_port(done_port), .busy(busy), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_ack(mem_ack)
  );

  ip_result_store #(.NUM_OUT(1), .LAST_BITS(8)) u_dut_single (
    .clock(clock), .reset(reset), .start_port(s_start), .input1(s_in),
    .base_addr(s_base), .done_port(s_done), .busy(s_busy), .mem_req(s_req),
    .mem_addr(s_addr), .mem_wdata(s_wdata), .mem_size(s_size), .mem_ack(s_ack)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] obs_addr [8];
  logic [63:0] obs_data [8];
  logic [6:0]  obs_size [8];
  int          nwr, ndone, done_cyc, unstable;
  logic        busy_after;

  // Reference: field0 = square, field1 = operand doubled up, field2 = operand+2
  // narrowed to the 16 stored bits of the last field.
  function automatic logic [63:0] exp_data(input logic [31:0] a, input int k);
    logic [31:0] s;
    case (k)
      0:       return 64'(a) * 64'(a);
      1:       return {a, a};
      default: begin
        s = a + 32'(k);
        return 64'(s[15:0]);
      end
    endcase
  endfunction

  function automatic logic [6:0] exp_size(input int k);
    return (k == 2) ? 7'd16 : 7'd64;
  endfunction

  // Runs one operation on the default DUT and records what it wrote. gap is the
  // number of low-ack cycles before each field is accepted; poke sprays start.
  task automatic run_seq(input logic [31:0] a, input logic [31:0] b, input int gap,
                         input bit poke);
    int          wcnt;
    logic        p_req, p_ack;
    logic [31:0] p_addr;
    logic [63:0] p_data;
    logic [6:0]  p_size;
    nwr = 0; ndone = 0; done_cyc = -1; unstable = 0; wcnt = 0;
    p_req = 0; p_ack = 0; p_addr = '0; p_data = '0; p_size = '0;
    for (int i = 0; i < 8; i++) begin
      obs_addr[i] = '0; obs_data[i] = '0; obs_size[i] = '0;
    end
    @(negedge clock);
    start_port = 1'b1; input1 = a; base_addr = b; mem_ack = 1'b0;
    #1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clock);
      start_port = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      input1     = $urandom;
      base_addr  = $urandom;
      if (mem_req) begin
        if (wcnt >= gap) begin
          mem_ack = 1'b1; wcnt = 0;
        end else begin
          mem_ack = 1'b0; wcnt++;
        end
      end else begin
        mem_ack = 1'($urandom_range(0, 1));
      end
      #1;
      if (mem_req && p_req && !p_ack &&
          (mem_addr !== p_addr || mem_wdata !== p_data || mem_size !== p_size))
        unstable++;
      if (mem_req && mem_ack) begin
        if (nwr < 8) begin
          obs_addr[nwr] = mem_addr; obs_data[nwr] = mem_wdata; obs_size[nwr] = mem_size;
        end
        nwr++;
      end
      if (done_port) begin
        ndone++;
        done_cyc = cyc;
      end
      p_req = mem_req; p_ack = mem_ack; p_addr = mem_addr; p_data = mem_wdata;
      p_size = mem_size;
      if (done_port) break;
    end
    @(negedge clock);
    start_port = 1'b0; mem_ack = 1'b0;
    #1;
    busy_after = busy;
  endtask

  task automatic test_reset();
    reset = 1'b1; start_port = 1'b1; mem_ack = 1'b1; s_start = 1'b1; s_ack = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    n_tests++;
    if (busy !== 1'b0 || done_port !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy=%b done=%b req=%b, want 0 0 0", busy, done_port, mem_req);
    end
    n_tests++;
    if (mem_addr !== 32'd0 || mem_wdata !== 64'd0 || mem_size !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_bus: addr=%h data=%h size=%0d, want zeros", mem_addr, mem_wdata,
               mem_size);
    end
    n_tests++;
    if (s_busy !== 1'b0 || s_req !== 1'b0 || s_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_single: busy=%b req=%b done=%b, want 0 0 0", s_busy, s_req, s_done);
    end
    @(negedge clock);
    reset = 1'b0; start_port = 1'b0; mem_ack = 1'b0; s_start = 1'b0; s_ack = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: busy=%b, want 0", busy);
    end
  endtask

  task automatic check_writes(input string name, input logic [31:0] a, input logic [31:0] b);
    n_tests++;
    if (nwr != 3 || ndone != 1) begin
      n_fail++;
      $display("FAIL %s_count: writes=%0d dones=%0d, want 3 1", name, nwr, ndone);
    end
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (obs_data[k] !== exp_data(a, k) || obs_addr[k] !== b + 32'(8 * k) ||
          obs_size[k] !== exp_size(k)) begin
        n_fail++;
        $display("FAIL %s_write%0d: got %h@%h size %0d, want %h@%h size %0d", name, k,
                 obs_data[k], obs_addr[k], obs_size[k], exp_data(a, k), b + 32'(8 * k),
                 exp_size(k));
      end
    end
  endtask

  task automatic test_basic();
    run_seq(32'h3, 32'h100, 0, 1'b0);
    check_writes("basic", 32'h3, 32'h100);
    n_tests++;
    if (done_cyc != 5) begin
      n_fail++;
      $display("FAIL basic_done_cycle: got S+%0d, want S+5", done_cyc);
    end
    n_tests++;
    if (busy_after !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle_after: busy=%b, want 0", busy_after);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    run_seq(a, b, 3, 1'b0);
    check_writes("backpressure", a, b);
    n_tests++;
    if (done_cyc != 14) begin
      n_fail++;
      $display("FAIL backpressure_done_cycle: got S+%0d, want S+14", done_cyc);
    end
    n_tests++;
    if (unstable != 0) begin
      n_fail++;
      $display("FAIL backpressure_stable: %0d changes while waiting, want 0", unstable);
    end
  endtask

  task automatic test_start_ignored();
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    run_seq(a, b, 1, 1'b1);
    check_writes("start_ignored", a, b);
    n_tests++;
    if (busy_after !== 1'b0) begin
      n_fail++;
      $display("FAIL start_ignored_done_cycle_start: busy=%b after done, want 0", busy_after);
    end
  endtask

  task automatic test_wrap();
    run_seq(32'hFFFF_FFFF, 32'hFFFF_FFF8, 0, 1'b0);
    check_writes("wrap", 32'hFFFF_FFFF, 32'hFFFF_FFF8);
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, b;
    bit          found;
    int          stray;
    a = $urandom; b = $urandom & 32'hFFFF_FFF8;
    found = 1'b0; stray = 0;
    @(negedge clock);
    start_port = 1'b1; input1 = a; base_addr = b; mem_ack = 1'b0;
    #1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      start_port = 1'b0;
      mem_ack = 1'b0;
      if (mem_req && mem_addr == b + 32'd8) begin
        found = 1'b1;
        break;
      end
      mem_ack = mem_req;
      #1;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL reset_mid_reach_field1: field1 request seen=%b, want 1", found);
    end
    reset = 1'b1; start_port = 1'b1;
    @(negedge clock);
    reset = 1'b0; start_port = 1'b0;
    #1;
    n_tests++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || done_port !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_abort: req=%b busy=%b done=%b, want 0 0 0", mem_req, busy,
               done_port);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      mem_ack = 1'b1;
      #1;
      if (mem_req || done_port) stray++;
    end
    n_tests++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_resume: %0d stray req/done cycles, want 0", stray);
    end
    a = $urandom; b = $urandom;
    run_seq(a, b, 0, 1'b0);
    check_writes("reset_mid_fresh", a, b);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    int          gap;
    bit          poke;
    for (int it = 0; it < 6; it++) begin
      a = $urandom; b = $urandom; gap = $urandom_range(0, 2); poke = 1'($urandom_range(0, 1));
      run_seq(a, b, gap, poke);
      check_writes("random", a, b);
      n_tests++;
      if (done_cyc != 2 + 3 * (gap + 1) || unstable != 0) begin
        n_fail++;
        $display("FAIL random_timing: done S+%0d unstable %0d, want S+%0d unstable 0",
                 done_cyc, unstable, 2 + 3 * (gap + 1));
      end
    end
  endtask

  task automatic test_single();
    logic [31:0] b;
    int          wr_cyc, dn_cyc, nw;
    logic [63:0] d;
    logic [31:0] ad;
    logic [6:0]  sz;
    b = $urandom; wr_cyc = -1; dn_cyc = -1; nw = 0; d = '0; ad = '0; sz = '0;
    @(negedge clock);
    s_start = 1'b1; s_in = 32'h12; s_base = b; s_ack = 1'b1;
    #1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clock);
      s_start = 1'b0; s_in = $urandom;
      #1;
      if (s_req && s_ack) begin
        nw++; wr_cyc = cyc; d = s_wdata; ad = s_addr; sz = s_size;
      end
      if (s_done) begin
        dn_cyc = cyc;
        break;
      end
    end
    n_tests++;
    if (nw != 1 || d !== 64'h44 || ad !== b || sz !== 7'd8) begin
      n_fail++;
      $display("FAIL single_write: n=%0d %h@%h size %0d, want 1 44@%h size 8", nw, d, ad, sz, b);
    end
    n_tests++;
    if (dn_cyc != 3 || wr_cyc != 3) begin
      n_fail++;
      $display("FAIL single_done_cycle: write S+%0d done S+%0d, want S+3 S+3", wr_cyc, dn_cyc);
    end
    s_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start_port = 1'b0; mem_ack = 1'b0; input1 = '0; base_addr = '0;
    s_start = 1'b0; s_ack = 1'b0; s_in = '0; s_base = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_start_ignored();
    test_wrap();
    test_reset_mid();
    test_random();
    test_single();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
